lab4_branch_branch_update_queue: RTL and testbench

// - Update-side counterpart of the gshare predictor. It records each fetched branch (PC and prediction) in

---
 rtl/lab4_branch_branch_update_queue.sv | 179 +++++++++++++++++
 tb/tb_lab4_branch_branch_update_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lab4_branch_branch_update_queue.sv
// Branch update queue: holds fetched branches (PC + prediction) in program order,
// pops the oldest on resolve, flags mispredicts and drives the predictor training
// port one cycle after each resolve.
//
// Optional build macro BRANCH_UPDATE_QUEUE_STATS_EN adds saturating 32-bit
// resolved/mispredict counters on stat_resolved and stat_mispred.
module lab4_branch_branch_update_queue #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    // Fetch side (enqueue)
    input  logic          fetch_val,
    output logic          fetch_rdy,
    input  logic [31:0]   fetch_pc,
    input  logic          fetch_pred,
    // Execute side (resolve / dequeue)
    input  logic          resolve_val,
    output logic          resolve_rdy,
    input  logic          resolve_taken,
    output logic          mispred,
    // Predictor training port
    output logic          upd_en,
    output logic          upd_val,
    output logic [31:0]   upd_pc,
    output logic [AW:0]   count
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    ,
    output logic [31:0]   stat_resolved,
    output logic [31:0]   stat_mispred
`endif
);

    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
    localparam logic [AW:0] CountOne  = (AW+1)'(1);
    localparam logic [AW-1:0] PtrOne  = AW'(1);

    // Entry storage; validity is implied by head/count, so the array needs no reset.
    logic [31:0]   pc_q   [DEPTH];
    logic          pred_q [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic          upd_en_q, upd_en_d;
    logic          upd_val_q, upd_val_d;
    logic [31:0]   upd_pc_q, upd_pc_d;

    logic          full;
    logic          empty;
    logic          enq_fire;
    logic          deq_fire;
    logic          mispred_int;
    logic          head_pred;
    logic [31:0]   head_pc;

    // Handshake and mispredict decode from current state.
    always_comb begin
        full        = (count_q == FullCount);
        empty       = (count_q == '0);
        // Fetch stalls while the predictor PC is borrowed for training; no full-bypass.
        fetch_rdy   = !full && !upd_en_q;
        resolve_rdy = !empty;
        enq_fire    = fetch_val && fetch_rdy;
        deq_fire    = resolve_val && resolve_rdy;
        head_pc     = pc_q[head_q];
        head_pred   = pred_q[head_q];
        mispred_int = deq_fire && (resolve_taken != head_pred);
        mispred     = mispred_int;
    end

    // Pointer and occupancy next-state; a mispredict squashes everything incl. a same-cycle enqueue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispred_int) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (deq_fire) begin
                head_d = head_q + PtrOne;
            end
            if (enq_fire) begin
                tail_d = tail_q + PtrOne;
            end
            if (enq_fire && !deq_fire) begin
                count_d = count_q + CountOne;
            end else if (deq_fire && !enq_fire) begin
                count_d = count_q - CountOne;
            end
        end
    end

    // Training port next-state: one update per dequeue, value/PC hold otherwise.
    always_comb begin
        upd_en_d  = 1'b0;
        upd_val_d = upd_val_q;
        upd_pc_d  = upd_pc_q;
        if (deq_fire) begin
            upd_en_d  = 1'b1;
            upd_val_d = resolve_taken;
            upd_pc_d  = head_pc;
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            upd_en_q  <= 1'b0;
            upd_val_q <= 1'b0;
            upd_pc_q  <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            upd_en_q  <= upd_en_d;
            upd_val_q <= upd_val_d;
            upd_pc_q  <= upd_pc_d;
        end
    end

    // Entry write at tail; skipped when the enqueue is squashed by a mispredict.
    always_ff @(posedge clk) begin
        if (enq_fire && !mispred_int && !reset) begin
            pc_q[tail_q]   <= fetch_pc;
            pred_q[tail_q] <= fetch_pred;
        end
    end

    // Output drive from registered state.
    always_comb begin
        upd_en  = upd_en_q;
        upd_val = upd_val_q;
        upd_pc  = upd_pc_q;
        count   = count_q;
    end

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    // Saturating event counters.
    always_comb begin
        stat_resolved_d = stat_resolved_q;
        stat_mispred_d  = stat_mispred_q;
        if (deq_fire && (stat_resolved_q != 32'hFFFF_FFFF)) begin
            stat_resolved_d = stat_resolved_q + 32'd1;
        end
        if (mispred_int && (stat_mispred_q != 32'hFFFF_FFFF)) begin
            stat_mispred_d = stat_mispred_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    // Statistics outputs.
    always_comb begin
        stat_resolved = stat_resolved_q;
        stat_mispred  = stat_mispred_q;
    end
`endif

endmodule

// File: tb/tb_lab4_branch_branch_update_queue.sv
// Directed self-checking bench for lab4_branch_branch_update_queue (DEPTH=4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_lab4_branch_branch_update_queue;

    logic        clk;
    logic        reset;
    logic        fetch_val;
    logic        fetch_rdy;
    logic [31:0] fetch_pc;
    logic        fetch_pred;
    logic        resolve_val;
    logic        resolve_rdy;
    logic        resolve_taken;
    logic        mispred;
    logic        upd_en;
    logic        upd_val;
    logic [31:0] upd_pc;
    logic [2:0]  count;
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;
`endif

    int n_pass  = 0;
    int n_total = 0;

    lab4_branch_branch_update_queue #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_val     (fetch_val),
        .fetch_rdy     (fetch_rdy),
        .fetch_pc      (fetch_pc),
        .fetch_pred    (fetch_pred),
        .resolve_val   (resolve_val),
        .resolve_rdy   (resolve_rdy),
        .resolve_taken (resolve_taken),
        .mispred       (mispred),
        .upd_en        (upd_en),
        .upd_val       (upd_val),
        .upd_pc        (upd_pc),
        .count         (count)
`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted enqueue (fetch must be ready).
    task automatic enq(input logic [31:0] pc, input logic pred);
        fetch_val  = 1'b1;
        fetch_pc   = pc;
        fetch_pred = pred;
        #1;
        chk("enq_rdy", {31'd0, fetch_rdy}, 32'd1);
        tick();
        fetch_val = 1'b0;
    endtask

    // One resolve, checking the combinational mispredict flag before the edge.
    task automatic res(input logic taken, input logic exp_mis);
        resolve_val   = 1'b1;
        resolve_taken = taken;
        #1;
        chk("mispred", {31'd0, mispred}, {31'd0, exp_mis});
        tick();
        resolve_val = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        fetch_val     = 1'b0;
        fetch_pc      = '0;
        fetch_pred    = 1'b0;
        resolve_val   = 1'b0;
        resolve_taken = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset / idle state
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_fetch_rdy", {31'd0, fetch_rdy}, 32'd1);
        chk("rst_resolve_rdy", {31'd0, resolve_rdy}, 32'd0);
        chk("rst_upd_en", {31'd0, upd_en}, 32'd0);
        chk("rst_upd_val", {31'd0, upd_val}, 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_mispred", {31'd0, mispred}, 32'd0);

        // Two correct predictions, in-order training
        enq(32'h100, 1'b1);
        enq(32'h104, 1'b0);
        chk("two_count", {29'd0, count}, 32'd2);
        res(1'b1, 1'b0);
        chk("t1_upd_en", {31'd0, upd_en}, 32'd1);
        chk("t1_upd_pc", upd_pc, 32'h100);
        chk("t1_upd_val", {31'd0, upd_val}, 32'd1);
        chk("t1_fetch_stall", {31'd0, fetch_rdy}, 32'd0);
        res(1'b0, 1'b0);
        chk("t2_upd_en", {31'd0, upd_en}, 32'd1);
        chk("t2_upd_pc", upd_pc, 32'h104);
        chk("t2_upd_val", {31'd0, upd_val}, 32'd0);
        chk("t2_count", {29'd0, count}, 32'd0);
        tick();
        chk("t3_upd_en", {31'd0, upd_en}, 32'd0);
        chk("t3_upd_pc_hold", upd_pc, 32'h104);
        chk("t3_fetch_rdy", {31'd0, fetch_rdy}, 32'd1);

        // Fill to DEPTH, then resolve one with fetch pressing
        enq(32'h0A0, 1'b1);
        enq(32'h0A4, 1'b1);
        enq(32'h0A8, 1'b1);
        enq(32'h0AC, 1'b1);
        chk("full_count", {29'd0, count}, 32'd4);
        chk("full_fetch_rdy", {31'd0, fetch_rdy}, 32'd0);
        fetch_val     = 1'b1;
        fetch_pc      = 32'h999;
        fetch_pred    = 1'b0;
        resolve_val   = 1'b1;
        resolve_taken = 1'b1;
        #1;
        chk("full_deq_fetch_rdy", {31'd0, fetch_rdy}, 32'd0);
        chk("full_deq_mispred", {31'd0, mispred}, 32'd0);
        tick();
        resolve_val = 1'b0;
        #1;
        chk("full_upd_fetch_rdy", {31'd0, fetch_rdy}, 32'd0);
        chk("full_upd_count", {29'd0, count}, 32'd3);
        chk("full_upd_pc", upd_pc, 32'h0A0);
        tick();
        fetch_val = 1'b0;
        chk("full_after_fetch_rdy", {31'd0, fetch_rdy}, 32'd1);
        chk("full_after_count", {29'd0, count}, 32'd3);
        chk("full_after_upd_en", {31'd0, upd_en}, 32'd0);
        res(1'b1, 1'b0);
        chk("drain1_pc", upd_pc, 32'h0A4);
        res(1'b1, 1'b0);
        chk("drain2_pc", upd_pc, 32'h0A8);
        chk("drain2_upd_en", {31'd0, upd_en}, 32'd1);
        res(1'b1, 1'b0);
        chk("drain3_pc", upd_pc, 32'h0AC);
        chk("drain_count", {29'd0, count}, 32'd0);
        tick();

        // Mispredict squashes younger entries and a same-cycle enqueue
        enq(32'h200, 1'b1);
        enq(32'h204, 1'b0);
        enq(32'h208, 1'b1);
        fetch_val  = 1'b1;
        fetch_pc   = 32'h20C;
        fetch_pred = 1'b1;
        res(1'b0, 1'b1);
        fetch_val = 1'b0;
        chk("mis_count", {29'd0, count}, 32'd0);
        chk("mis_resolve_rdy", {31'd0, resolve_rdy}, 32'd0);
        chk("mis_upd_en", {31'd0, upd_en}, 32'd1);
        chk("mis_upd_pc", upd_pc, 32'h200);
        chk("mis_upd_val", {31'd0, upd_val}, 32'd0);
        res(1'b1, 1'b0);
        chk("empty_res_upd_en", {31'd0, upd_en}, 32'd0);
        chk("empty_res_count", {29'd0, count}, 32'd0);
        chk("empty_res_upd_pc", upd_pc, 32'h200);
        chk("empty_res_upd_val", {31'd0, upd_val}, 32'd0);

        // Simultaneous enq/deq at count=2, wrapping the pointers
        enq(32'h300, 1'b1);
        enq(32'h304, 1'b1);
        for (int k = 0; k < 7; k++) begin
            fetch_val     = 1'b1;
            fetch_pc      = 32'h308 + 32'(4 * k);
            fetch_pred    = 1'b1;
            resolve_val   = 1'b1;
            resolve_taken = 1'b1;
            #1;
            chk("pair_fetch_rdy", {31'd0, fetch_rdy}, 32'd1);
            chk("pair_mispred", {31'd0, mispred}, 32'd0);
            tick();
            fetch_val   = 1'b0;
            resolve_val = 1'b0;
            chk("pair_count", {29'd0, count}, 32'd2);
            chk("pair_upd_pc", upd_pc, 32'h300 + 32'(4 * k));
            tick();
        end
        res(1'b1, 1'b0);
        chk("wrap_drain1_pc", upd_pc, 32'h31C);
        res(1'b1, 1'b0);
        chk("wrap_drain2_pc", upd_pc, 32'h320);
        chk("wrap_count", {29'd0, count}, 32'd0);
        tick();

        // Reset mid-operation drops entries and a pending update
        enq(32'h400, 1'b1);
        enq(32'h404, 1'b1);
        res(1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_count", {29'd0, count}, 32'd0);
        chk("midrst_upd_en", {31'd0, upd_en}, 32'd0);
        chk("midrst_upd_pc", upd_pc, 32'd0);
        chk("midrst_resolve_rdy", {31'd0, resolve_rdy}, 32'd0);

`ifdef BRANCH_UPDATE_QUEUE_STATS_EN
        chk("stat_rst_resolved", stat_resolved, 32'd0);
        chk("stat_rst_mispred", stat_mispred, 32'd0);
        enq(32'h500, 1'b1);
        enq(32'h504, 1'b1);
        enq(32'h508, 1'b1);
        res(1'b1, 1'b0);
        res(1'b0, 1'b1);
        tick();
        enq(32'h600, 1'b1);
        enq(32'h604, 1'b1);
        enq(32'h608, 1'b1);
        res(1'b1, 1'b0);
        res(1'b1, 1'b0);
        res(1'b0, 1'b1);
        chk("stat_resolved", stat_resolved, 32'd5);
        chk("stat_mispred", stat_mispred, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("stat_clr_resolved", stat_resolved, 32'd0);
        chk("stat_clr_mispred", stat_mispred, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
